// File: rtl/fetch_pkg.sv
// Shared defaults and sizing helpers for the instruction fetch unit and its FIFOs.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH_DEF = 4;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(FQ_DEPTH_DEF);

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO with synchronous clear; head entry is visible on data_o
// whenever count_o is non-zero.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = FQ_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            data_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    // Clear has priority over any push/pop in the same cycle.
    always_comb begin
        do_push_c = push_i && (count_q != CNT_W'(DEPTH)) && !clear_i;
        do_pop_c  = pop_i && (count_q != '0) && !clear_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential PC requests, in-order response
// capture into a show-ahead queue, and redirect flush with stale-response dropping.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_word,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned CNT_W = cnt_width(FQ_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned FQ_W  = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  pend_cnt, fq_cnt;
    logic [ADDR_W-1:0] pend_head;
    logic [FQ_W-1:0]   fq_head;
    logic [FQ_W-1:0]   fq_wdata_c;
    logic              credit_ok_c;
    logic              req_fire_c;
    logic              rsp_keep_c;
    logic              inst_fire_c;
    logic              fq_full_c;
    logic              pend_empty_c;

    // Handshakes and queue-side controls. Credits cover requests still in
    // flight (including ones that will be dropped) plus queued instructions.
    always_comb begin
        credit_ok_c    = ({1'b0, pend_cnt} + {1'b0, fq_cnt}) < SUM_W'(FQ_DEPTH);
        imem_req_valid = credit_ok_c && !redirect_valid && reset;
        imem_req_addr  = pc_q;
        req_fire_c     = imem_req_valid && imem_req_ready;
        rsp_keep_c     = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        fq_wdata_c     = {pend_head, imem_rsp_data};
        fq_full_c      = (fq_cnt == CNT_W'(FQ_DEPTH));
        pend_empty_c   = (pend_cnt == '0);
        inst_valid     = (fq_cnt != '0);
        inst_fire_c    = inst_valid && inst_ready && !redirect_valid;
        inst_pc        = inst_valid ? fq_head[FQ_W-1 -: ADDR_W] : '0;
        inst_word      = inst_valid ? fq_head[INST_W-1:0] : '0;
    end

    // A response landing on the redirect edge is itself discarded, so the
    // drop budget covers only what remains outstanding after that edge.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~ADDR_W'(3);
            drop_d = pend_cnt - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire_c) pc_d = pc_q + ADDR_W'(4);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FQ_DEPTH)
    ) u_pend_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (1'b0),
        .push_i  (req_fire_c),
        .data_i  (pc_q),
        .pop_i   (imem_rsp_valid),
        .data_o  (pend_head),
        .count_o (pend_cnt)
    );

    fetch_fifo #(
        .WIDTH (FQ_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (redirect_valid),
        .push_i  (rsp_keep_c),
        .data_i  (fq_wdata_c),
        .pop_i   (inst_fire_c),
        .data_o  (fq_head),
        .count_o (fq_cnt)
    );

    // Memory must only answer requests it accepted, and credits keep the queue from overflowing.
    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && fq_full_c));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && pend_empty_c));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model: in-order
// memory with per-request latency, epoch-tagged requests, and an instruction queue.
module tb_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mrec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } inst_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst_word;
    logic [AW-1:0] inst_pc;

    fetch_unit #(
        .ADDR_W   (AW),
        .INST_W   (IW),
        .RESET_PC (RPC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    mrec_t       memq[$];
    inst_t       fq[$];
    logic [31:0] dlv[$];
    logic [31:0] m_pc;
    int          epoch = 0;
    int          edges = 0;
    int          n_acc = 0;
    int unsigned rdy_pct, irdy_pct, redir_pct, lat_min, lat_max;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt;
    logic        s_iv, s_rv;
    logic [31:0] s_ipc;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the edge, check at the falling edge, advance the model.
    task automatic tick();
        logic        acc, rsp, redir, pop, exp_rv;
        logic [31:0] acc_addr;
        mrec_t       r;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
        redirect_pc    = force_redir ? force_tgt : $urandom;
        force_redir    = 1'b0;
        imem_rsp_valid = (memq.size() != 0) && (memq[0].due <= edges + 1);
        imem_rsp_data  = imem_rsp_valid ? mem_f(memq[0].addr) : $urandom;
        @(negedge clk);
        exp_rv = (memq.size() + fq.size() < DEPTH) && !redirect_valid;
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("req_addr", imem_req_addr, m_pc);
        check_eq("inst_valid", 32'(inst_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check_eq("inst_pc", inst_pc, fq[0].pc);
            check_eq("inst_word", inst_word, fq[0].word);
        end
        s_iv     = inst_valid;
        s_ipc    = inst_pc;
        s_rv     = imem_req_valid;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_rsp_valid;
        redir    = redirect_valid;
        pop      = (fq.size() != 0) && inst_ready && !redir;
        if (inst_valid && inst_ready) dlv.push_back(inst_pc);
        @(posedge clk);
        edges++;
        #1;
        if (redir) begin
            epoch++;
            fq.delete();
            m_pc = redirect_pc & ~32'd3;
        end else if (pop) begin
            fq.delete(0);
        end
        if (rsp) begin
            r = memq.pop_front();
            if (r.epoch == epoch) fq.push_back('{pc: r.addr, word: mem_f(r.addr)});
        end
        if (acc) begin
            memq.push_back('{addr: acc_addr, epoch: epoch,
                             due: edges + int'($urandom_range(lat_max, lat_min))});
            if (!redir) m_pc = m_pc + 32'd4;
            n_acc++;
        end
    endtask

    task automatic set_mode(input int unsigned rdy, input int unsigned irdy,
                            input int unsigned redir, input int unsigned lmin,
                            input int unsigned lmax);
        rdy_pct = rdy; irdy_pct = irdy; redir_pct = redir; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        int n0;
        logic [31:0] got;
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        m_pc = RPC;
        #12;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst_word", inst_word, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Zero-wait memory, always-ready decode: sequential PCs across the wrap, full rate.
        set_mode(100, 100, 0, 1, 1);
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 4; i++) begin
            got = (i < dlv.size()) ? dlv[i] : 32'hDEAD_BEEF;
            check_eq($sformatf("wrap_pc%0d", i), got, RPC + 32'(4 * i));
        end
        n0 = dlv.size();
        for (int i = 0; i < 30; i++) tick();
        check_eq("throughput", 32'(dlv.size() - n0), 32'd30);

        // Decode stalled: only FQ_DEPTH requests may issue, head holds steady.
        set_mode(100, 0, 0, 1, 1);
        force_redir = 1'b1; force_tgt = 32'h0000_0200;
        tick();
        n0 = n_acc;
        for (int i = 0; i < 10; i++) tick();
        check_eq("stall_accepts", 32'(n_acc - n0), DEPTH);
        check_eq("stall_req_valid", 32'(s_rv), 32'd0);
        check_eq("stall_head_pc", s_ipc, 32'h0000_0200);
        set_mode(100, 100, 0, 1, 1);
        n0 = dlv.size();
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 8; i++) begin
            got = (n0 + i < dlv.size()) ? dlv[n0 + i] : 32'hDEAD_BEEF;
            check_eq($sformatf("resume_pc%0d", i), got, 32'h0000_0200 + 32'(4 * i));
        end

        // Latency 3: redirect to an unaligned target with three fetches outstanding.
        set_mode(100, 100, 0, 3, 3);
        for (int i = 0; i < 50 && memq.size() != 3; i++) tick();
        check_eq("lat3_inflight_reached", 32'(memq.size()), 32'd3);
        force_redir = 1'b1; force_tgt = 32'h0000_0103;
        tick();
        s_iv = 1'b0;
        for (int i = 0; i < 30 && !s_iv; i++) tick();
        check_eq("lat3_redir_seen", 32'(s_iv), 32'd1);
        check_eq("lat3_redir_pc", s_ipc, 32'h0000_0100);

        // Redirect on the same edge as a response and a decode pop.
        set_mode(100, 100, 0, 1, 1);
        for (int i = 0; i < 50 && !(memq.size() != 0 && memq[0].due <= edges + 1 && fq.size() != 0); i++)
            tick();
        force_redir = 1'b1; force_tgt = 32'h0000_03C0;
        tick();
        tick();
        check_eq("coinc_flush", 32'(s_iv), 32'd0);
        for (int i = 0; i < 30 && !s_iv; i++) tick();
        check_eq("coinc_redir_seen", 32'(s_iv), 32'd1);
        check_eq("coinc_redir_pc", s_ipc, 32'h0000_03C0);

        // Randomized traffic: backpressure, variable latency, sporadic redirects.
        set_mode(70, 60, 3, 1, 4);
        for (int i = 0; i < 800; i++) tick();

        // Asynchronous reset with the queue full.
        set_mode(100, 0, 0, 1, 1);
        for (int i = 0; i < 60 && fq.size() != DEPTH; i++) tick();
        check_eq("full_before_reset", 32'(fq.size()), DEPTH);
        #2;
        reset = 1'b0;
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        check_eq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("mid_rst_inst_word", inst_word, 32'd0);
        check_eq("mid_rst_inst_pc", inst_pc, 32'd0);
        memq.delete(); fq.delete(); epoch++; m_pc = RPC;
        @(posedge clk); @(posedge clk);
        edges += 2;
        #1;
        reset = 1'b1;
        set_mode(100, 100, 0, 1, 2);
        n0 = dlv.size();
        for (int i = 0; i < 20; i++) tick();
        got = (n0 < dlv.size()) ? dlv[n0] : 32'hDEAD_BEEF;
        check_eq("post_rst_first_pc", got, RPC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC and memory address width in bits.
REQ-002 Parameter INST_W, default 32, instruction word width in bits.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-004 Parameter FQ_DEPTH, default 4, power of two >= 2: maximum fetches in flight plus queued.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  ADDR_W  byte address of requested word.
REQ-010 imem_rsp_valid  input  1  in-order response valid; memory never back-pressured.
REQ-011 imem_rsp_data  input  INST_W  returned instruction word.
REQ-012 redirect_valid  input  1  branch/jump/trap redirect, one-cycle pulse.
REQ-013 redirect_pc  input  ADDR_W  redirect target.
REQ-014 inst_valid  output  1  instruction available to decode.
REQ-015 inst_ready  input  1  decode accepts instruction.
REQ-016 inst_word  output  INST_W  instruction delivered.
REQ-017 inst_pc  output  ADDR_W  byte address of inst_word.

Function
REQ-018 PC is a byte address; each accepted request (imem_req_valid & imem_req_ready) advances PC by 4, wrapping modulo 2^ADDR_W.
REQ-019 imem_req_addr = PC; imem_req_valid = 1 when credits available (in-flight + queued < FQ_DEPTH), not in reset, and redirect_valid = 0.
REQ-020 Each accepted request pushes its address into a pending-PC FIFO; each imem_rsp_valid pops it and pushes {pc, data} into the fetch queue.
REQ-021 Credit rule guarantees the fetch queue never overflows; a response arriving with a full queue is a protocol error (assertion).
REQ-022 inst_valid = fetch queue not empty; inst_word/inst_pc = queue head, zero-latency show-ahead.
REQ-023 Queue pops on inst_valid & inst_ready; inst_word and inst_pc stay stable while inst_valid & !inst_ready.
REQ-024 Min latency: request accepted at edge N, response at edge N+k, inst_valid high after edge N+k.
REQ-025 Throughput: one instruction per cycle sustained when memory responds every cycle and inst_ready = 1.
REQ-026 Redirect: on edge with redirect_valid = 1, PC <= {redirect_pc[ADDR_W-1:2], 2'b00}, fetch queue cleared, drop counter <= current in-flight count (including a request accepted that edge excluded, since none issues on redirect).
REQ-027 While drop counter > 0, each response decrements it and is discarded (no queue push); pending-PC FIFO still pops.
REQ-028 Redirect and response same edge: response counted as in-flight and discarded.
REQ-029 Redirect and inst_ready pop same edge: flush wins; inst_valid = 0 after the edge; popped entry counts as delivered.
REQ-030 Back-to-back redirects: latest target wins; drop counter reloaded with in-flight count.
REQ-031 First request issues on the first rising edge after reset deasserts, at address RESET_PC.

Reset
REQ-032 reset = 0 asynchronously forces PC = RESET_PC, in-flight = 0, drop counter = 0, both FIFOs empty.
REQ-033 During reset imem_req_valid = 0, inst_valid = 0, inst_word = 0, inst_pc = 0.
REQ-034 Reset mid-operation abandons outstanding fetches; memory is reset concurrently, so no stale responses follow.

Structure
REQ-035 Package fetch_pkg holds default ADDR_W, INST_W, RESET_PC, FQ_DEPTH and the clog2-derived counter width.
REQ-036 One sub-module fetch_fifo (parametrised width/depth, show-ahead, sync clear) instantiated twice: pending-PC FIFO and fetch queue.

Verification
REQ-037 Reset, zero-wait memory, inst_ready = 1 -> inst_pc 0x0,0x4,0x8,... one per cycle, words match memory.
REQ-038 inst_ready = 0 for 10 cycles -> exactly FQ_DEPTH requests issued, then imem_req_valid = 0; outputs stable; resume yields no loss/duplicate.
REQ-039 Memory latency 3, redirect to 0x103 with 3 in flight -> 3 responses dropped, next inst_pc = 0x100.
REQ-040 RESET_PC = 0xFFFF_FFF8 -> inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-041 Assert reset mid-stream with queue full -> outputs zero immediately (async), first fetch after release at RESET_PC.
REQ-042 Redirect coincident with response and with inst_ready pop -> both discarded/flushed, inst_valid = 0 next cycle, next inst_pc = target.
